// File: rtl/simple_rx_check.sv
// Receive-side checker for generator test packets: a two-beat packet (header, payload)
// is judged against expected constants, and good/bad verdicts plus byte statistics are kept.
module simple_rx_check #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  // Upper header bytes are zero as emitted by the generator.
  parameter logic [C_S_AXIS_DATA_WIDTH-1:0] C_EXP_HDR =
    {128'h0, 16'h0200, 16'h0888, 48'hBBBBBBBBBBBB, 48'hAAAAAAAAAAAA},
  parameter logic [C_S_AXIS_DATA_WIDTH-1:0] C_EXP_PAYLOAD =
    256'hDDDDDDDDDDDDDCCCCCCCCCCAAAAAAAAAAAFFFFFFEEEEE,
  parameter logic [15:0] C_EXP_LEN = 16'h0040
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESET,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                              S_AXIS_TVALID,
  input  logic                              S_AXIS_TLAST,
  output logic                              S_AXIS_TREADY,
  input  logic                              rx_pause,
  input  logic                              rst_cntrs,
  output logic [31:0]                       good_count,
  output logic [31:0]                       err_count,
  output logic [31:0]                       byte_count,
  output logic [2:0]                        last_err,
  output logic                              pkt_good,
  output logic                              pkt_bad
);

  localparam int STRB_W = C_S_AXIS_DATA_WIDTH / 8;

  typedef enum logic [1:0] {HDR, BODY, DRAIN} state_t;

  state_t      state, state_nxt;
  logic        bad_flag, bad_flag_nxt;
  logic [2:0]  err_code, err_code_nxt;
  logic        good_hit, bad_hit;
  logic [2:0]  bad_code;
  logic        accept, strb_full, hdr_bad, pay_bad;
  logic [31:0] beat_bytes;
  logic        unused_tuser;

  assign S_AXIS_TREADY = ~rx_pause & ~S_AXI_ARESET;
  assign accept        = S_AXIS_TVALID & S_AXIS_TREADY;
  assign strb_full     = &S_AXIS_TSTRB;
  assign hdr_bad       = (S_AXIS_TDATA != C_EXP_HDR) | ~strb_full |
                         (S_AXIS_TUSER[15:0] != C_EXP_LEN);
  assign pay_bad       = (S_AXIS_TDATA != C_EXP_PAYLOAD) | ~strb_full;
  assign unused_tuser  = ^S_AXIS_TUSER[C_S_AXIS_TUSER_WIDTH-1:16];

  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < STRB_W; i++)
      beat_bytes = beat_bytes + 32'(S_AXIS_TSTRB[i]);
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET)
      state <= HDR;
    else if (accept)
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HDR:     if (!S_AXIS_TLAST) state_nxt = BODY;
      BODY:    state_nxt = S_AXIS_TLAST ? HDR : DRAIN;
      DRAIN:   if (S_AXIS_TLAST) state_nxt = HDR;
      default: state_nxt = HDR;
    endcase
  end

  // Verdict for the beat being accepted; the earliest error code of a packet sticks.
  always_comb begin
    good_hit     = 1'b0;
    bad_hit      = 1'b0;
    bad_code     = err_code;
    bad_flag_nxt = bad_flag;
    err_code_nxt = err_code;
    if (accept) begin
      case (state)
        HDR: begin
          if (S_AXIS_TLAST) begin
            bad_hit      = 1'b1;
            bad_code     = 3'd1;
            bad_flag_nxt = 1'b0;
            err_code_nxt = 3'd0;
          end else begin
            bad_flag_nxt = hdr_bad;
            err_code_nxt = hdr_bad ? 3'd2 : 3'd0;
          end
        end
        BODY: begin
          if (S_AXIS_TLAST) begin
            if (bad_flag) begin
              bad_hit = 1'b1;
            end else if (pay_bad) begin
              bad_hit  = 1'b1;
              bad_code = 3'd3;
            end else begin
              good_hit = 1'b1;
            end
            bad_flag_nxt = 1'b0;
            err_code_nxt = 3'd0;
          end else begin
            bad_flag_nxt = 1'b1;
            err_code_nxt = bad_flag ? err_code : 3'd4;
          end
        end
        DRAIN: begin
          if (S_AXIS_TLAST) begin
            bad_hit      = 1'b1;
            bad_flag_nxt = 1'b0;
            err_code_nxt = 3'd0;
          end
        end
        default: begin
          bad_flag_nxt = 1'b0;
          err_code_nxt = 3'd0;
        end
      endcase
    end
  end

  // Counter clear wins over any increment landing in the same cycle.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      bad_flag   <= 1'b0;
      err_code   <= 3'd0;
      pkt_good   <= 1'b0;
      pkt_bad    <= 1'b0;
      good_count <= '0;
      err_count  <= '0;
      byte_count <= '0;
      last_err   <= 3'd0;
    end else begin
      bad_flag <= bad_flag_nxt;
      err_code <= err_code_nxt;
      pkt_good <= good_hit;
      pkt_bad  <= bad_hit;
      if (rst_cntrs) begin
        good_count <= '0;
        err_count  <= '0;
        byte_count <= '0;
        last_err   <= 3'd0;
      end else begin
        if (good_hit)
          good_count <= good_count + 32'd1;
        if (bad_hit) begin
          err_count <= err_count + 32'd1;
          last_err  <= bad_code;
        end
        if (accept)
          byte_count <= byte_count + beat_bytes;
      end
    end
  end

endmodule

// File: tb/tb_simple_rx_check.sv
// Bench for simple_rx_check: packet-level reference model compared every cycle,
// plus directed scenarios with hand-computed literal results.
module tb_simple_rx_check;

  localparam int DW = 256;
  localparam int UW = 128;
  localparam int SW = DW / 8;
  localparam logic [DW-1:0] EXP_HDR =
    {128'h0, 16'h0200, 16'h0888, 48'hBBBBBBBBBBBB, 48'hAAAAAAAAAAAA};
  localparam logic [DW-1:0] EXP_PAY = 256'hDDDDDDDDDDDDDCCCCCCCCCCAAAAAAAAAAAFFFFFFEEEEE;
  localparam logic [15:0]   EXP_LEN = 16'h0040;
  localparam logic [UW-1:0] GOOD_USER = 128'h04800040;
  localparam logic [SW-1:0] ALL_STRB = '1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          areset = 1'b1;
  logic [DW-1:0] tdata = '0;
  logic [SW-1:0] tstrb = '0;
  logic [UW-1:0] tuser = '0;
  logic          tvalid = 1'b0, tlast = 1'b0, tready;
  logic          rx_pause = 1'b0, rst_cntrs = 1'b0;
  logic [31:0]   good_count, err_count, byte_count;
  logic [2:0]    last_err;
  logic          pkt_good, pkt_bad;

  simple_rx_check dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(areset),
    .S_AXIS_TDATA(tdata), .S_AXIS_TSTRB(tstrb), .S_AXIS_TUSER(tuser),
    .S_AXIS_TVALID(tvalid), .S_AXIS_TLAST(tlast), .S_AXIS_TREADY(tready),
    .rx_pause(rx_pause), .rst_cntrs(rst_cntrs),
    .good_count(good_count), .err_count(err_count), .byte_count(byte_count),
    .last_err(last_err), .pkt_good(pkt_good), .pkt_bad(pkt_bad)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [UW-1:0] user;
  } beat_t;

  beat_t       pkt_q[$];
  bit          live = 1'b0;
  logic        m_good, m_bad;
  logic [31:0] m_goodc, m_errc, m_bytes;
  logic [2:0]  m_lerr;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-packet judgement: error codes in order of detection.
  function automatic logic [2:0] classify();
    if (pkt_q.size() == 1) return 3'd1;
    if (pkt_q[0].data != EXP_HDR || pkt_q[0].strb != ALL_STRB || pkt_q[0].user[15:0] != EXP_LEN)
      return 3'd2;
    if (pkt_q.size() > 2) return 3'd4;
    if (pkt_q[1].data != EXP_PAY || pkt_q[1].strb != ALL_STRB) return 3'd3;
    return 3'd0;
  endfunction

  always @(posedge clk) begin
    logic [2:0] code;
    beat_t      b;
    if (areset) begin
      live = 1'b1;
      m_good = 0; m_bad = 0; m_goodc = 0; m_errc = 0; m_bytes = 0; m_lerr = 0;
      pkt_q.delete();
    end else begin
      m_good = 0;
      m_bad  = 0;
      if (tvalid && !rx_pause) begin
        b.data = tdata; b.strb = tstrb; b.user = tuser;
        pkt_q.push_back(b);
        m_bytes = m_bytes + 32'($countones(tstrb));
        if (tlast) begin
          code = classify();
          pkt_q.delete();
          if (code == 3'd0) begin
            m_good  = 1;
            m_goodc = m_goodc + 1;
          end else begin
            m_bad  = 1;
            m_errc = m_errc + 1;
            m_lerr = code;
          end
        end
      end
      if (rst_cntrs) begin
        m_goodc = 0; m_errc = 0; m_bytes = 0; m_lerr = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      checkOutput("tready", 32'(tready), 32'(!rx_pause && !areset));
      checkOutput("pkt_good", 32'(pkt_good), 32'(m_good));
      checkOutput("pkt_bad", 32'(pkt_bad), 32'(m_bad));
      checkOutput("good_count", good_count, m_goodc);
      checkOutput("err_count", err_count, m_errc);
      checkOutput("byte_count", byte_count, m_bytes);
      checkOutput("last_err", 32'(last_err), 32'(m_lerr));
    end
  end

  task automatic applyStimulus(input logic [DW-1:0] d, input logic [SW-1:0] s,
                               input logic [UW-1:0] u, input logic l);
    bit done = 0;
    tdata = d; tstrb = s; tuser = u; tlast = l; tvalid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(posedge clk);
      if (tready) done = 1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL beat_accept: got no handshake expected handshake at %0t", $time);
    end
    #2;
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic doReset();
    areset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    areset = 1'b0;
  endtask

  task automatic goodPacket();
    applyStimulus(EXP_HDR, ALL_STRB, GOOD_USER, 1'b0);
    applyStimulus(EXP_PAY, ALL_STRB, GOOD_USER, 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    doReset();
    @(negedge clk);
    checkOutput("lit_reset_good", good_count, 32'd0);
    checkOutput("lit_reset_lerr", 32'(last_err), 32'd0);

    // Good two-beat packet
    goodPacket();
    @(negedge clk);
    checkOutput("lit_good_pulse", 32'(pkt_good), 32'd1);
    checkOutput("lit_good_count", good_count, 32'd1);
    checkOutput("lit_good_bytes", byte_count, 32'd64);
    @(negedge clk);
    checkOutput("lit_good_pulse_end", 32'(pkt_good), 32'd0);

    // Short packet
    doReset();
    applyStimulus(EXP_PAY, ALL_STRB, GOOD_USER, 1'b1);
    @(negedge clk);
    checkOutput("lit_short_bad", 32'(pkt_bad), 32'd1);
    checkOutput("lit_short_err", err_count, 32'd1);
    checkOutput("lit_short_lerr", 32'(last_err), 32'd1);
    checkOutput("lit_short_bytes", byte_count, 32'd32);

    // Header bit 0 flipped, then a clean packet
    doReset();
    applyStimulus(EXP_HDR ^ 256'd1, ALL_STRB, GOOD_USER, 1'b0);
    applyStimulus(EXP_PAY, ALL_STRB, GOOD_USER, 1'b1);
    @(negedge clk);
    checkOutput("lit_hdr_bad", 32'(pkt_bad), 32'd1);
    checkOutput("lit_hdr_lerr", 32'(last_err), 32'd2);
    goodPacket();
    @(negedge clk);
    checkOutput("lit_after_hdr_good", good_count, 32'd1);
    checkOutput("lit_after_hdr_lerr", 32'(last_err), 32'd2);
    checkOutput("lit_after_hdr_bytes", byte_count, 32'd128);

    // Long packet, then a long packet whose header length is wrong
    doReset();
    applyStimulus(EXP_HDR, ALL_STRB, GOOD_USER, 1'b0);
    applyStimulus(EXP_PAY, ALL_STRB, GOOD_USER, 1'b0);
    applyStimulus(EXP_PAY, ALL_STRB, GOOD_USER, 1'b1);
    @(negedge clk);
    checkOutput("lit_long_bad", 32'(pkt_bad), 32'd1);
    checkOutput("lit_long_lerr", 32'(last_err), 32'd4);
    checkOutput("lit_long_bytes", byte_count, 32'd96);
    applyStimulus(EXP_HDR, ALL_STRB, 128'h41, 1'b0);
    applyStimulus(EXP_PAY, ALL_STRB, GOOD_USER, 1'b0);
    applyStimulus(EXP_PAY, ALL_STRB, GOOD_USER, 1'b0);
    applyStimulus(EXP_PAY, ALL_STRB, GOOD_USER, 1'b1);
    @(negedge clk);
    checkOutput("lit_long_hdr_lerr", 32'(last_err), 32'd2);
    checkOutput("lit_long_hdr_err", err_count, 32'd2);

    // Payload with partial strobes
    doReset();
    applyStimulus(EXP_HDR, ALL_STRB, GOOD_USER, 1'b0);
    applyStimulus(EXP_PAY, 32'h0000FFFF, GOOD_USER, 1'b1);
    @(negedge clk);
    checkOutput("lit_pay_lerr", 32'(last_err), 32'd3);
    checkOutput("lit_pay_bytes", byte_count, 32'd48);

    // Reset in the middle of a packet abandons it
    doReset();
    applyStimulus(EXP_HDR, ALL_STRB, GOOD_USER, 1'b0);
    doReset();
    goodPacket();
    @(negedge clk);
    checkOutput("lit_midrst_good", 32'(pkt_good), 32'd1);
    checkOutput("lit_midrst_err", err_count, 32'd0);
    checkOutput("lit_midrst_bytes", byte_count, 32'd64);

    // Backpressure toggled while beats are held
    doReset();
    rx_pause = 1'b1;
    fork
      applyStimulus(EXP_HDR, ALL_STRB, GOOD_USER, 1'b0);
      begin repeat (3) @(posedge clk); #1 rx_pause = 1'b0; end
    join
    rx_pause = 1'b1;
    fork
      applyStimulus(EXP_PAY, ALL_STRB, GOOD_USER, 1'b1);
      begin
        repeat (2) @(posedge clk); #1 rx_pause = 1'b0;
        @(posedge clk); #1 rx_pause = 1'b1;
        @(posedge clk); #1 rx_pause = 1'b0;
      end
    join
    @(negedge clk);
    checkOutput("lit_pause_good", good_count, 32'd1);
    checkOutput("lit_pause_bytes", byte_count, 32'd64);

    // Counter clear on the same edge that raises pkt_good
    applyStimulus(EXP_HDR, ALL_STRB, GOOD_USER, 1'b0);
    rst_cntrs = 1'b1;
    applyStimulus(EXP_PAY, ALL_STRB, GOOD_USER, 1'b1);
    rst_cntrs = 1'b0;
    @(negedge clk);
    checkOutput("lit_clr_pulse", 32'(pkt_good), 32'd1);
    checkOutput("lit_clr_good", good_count, 32'd0);
    checkOutput("lit_clr_bytes", byte_count, 32'd0);
    checkOutput("lit_clr_err", err_count, 32'd0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/simple_rx_check.md
SIMPLE_RX_CHECK -- requirements
Module: simple_rx_check

Interface
REQ-001 SHALL have parameter C_S_AXIS_DATA_WIDTH, default 256, stream data width in bits.
REQ-002 SHALL have parameter C_S_AXIS_TUSER_WIDTH, default 128, stream sideband width in bits.
REQ-003 SHALL have parameter C_EXP_HDR, default 256-bit: [47:0]=0xAAAAAAAAAAAA, [95:48]=0xBBBBBBBBBBBB, [111:96]=0x0888, [127:112]=0x0200, remainder as generator header; expected beat-0 data.
REQ-004 SHALL have parameter C_EXP_PAYLOAD, default 256'hDDDDDDDDDDDDDCCCCCCCCCCAAAAAAAAAAAFFFFFFEEEEE; expected beat-1 data.
REQ-005 SHALL have parameter C_EXP_LEN, default 16'h0040, expected TUSER[15:0] on beat 0.
REQ-006 S_AXI_ACLK  in  1  sole clock; all logic on rising edge.
REQ-007 S_AXI_ARESET  in  1  reset, synchronous, active-high.
REQ-008 S_AXIS_TDATA  in  C_S_AXIS_DATA_WIDTH  stream data.
REQ-009 S_AXIS_TSTRB  in  C_S_AXIS_DATA_WIDTH/8  byte strobes.
REQ-010 S_AXIS_TUSER  in  C_S_AXIS_TUSER_WIDTH  sideband; [15:0] packet length.
REQ-011 S_AXIS_TVALID  in  1;  S_AXIS_TLAST  in  1.
REQ-012 S_AXIS_TREADY  out  1  accept; combinational = ~rx_pause & ~S_AXI_ARESET.
REQ-013 rx_pause  in  1  backpressure request; rst_cntrs  in  1  clears counters.
REQ-014 good_count, err_count, byte_count  out  32 each  statistics; last_err  out  3  error code.
REQ-015 pkt_good, pkt_bad  out  1 each  one-cycle registered verdict pulses.

Function
REQ-016 Beat accepted SHALL mean S_AXIS_TVALID & S_AXIS_TREADY on a rising edge; no other input sampled.
REQ-017 FSM SHALL have states HDR, BODY, DRAIN; advances only on accepted beats.
REQ-018 HDR, TLAST=1: short packet, pkt_bad, last_err=1, stay HDR.
REQ-019 HDR, TLAST=0: header bad if TDATA!=C_EXP_HDR or TSTRB!=all-ones or TUSER[15:0]!=C_EXP_LEN; store bad flag and code 2; go BODY.
REQ-020 BODY, TLAST=1: payload bad if TDATA!=C_EXP_PAYLOAD or TSTRB!=all-ones (code 3); verdict good only if no flag; go HDR.
REQ-021 BODY, TLAST=0: long packet, set flag (code 4 unless earlier code held), go DRAIN.
REQ-022 DRAIN: discard beats; on TLAST=1 issue pkt_bad, go HDR.
REQ-023 Per packet, first detected error code SHALL be reported; flag cleared on return to HDR.
REQ-024 pkt_good/pkt_bad SHALL assert exactly one cycle, the cycle after the final accepted beat; never both.
REQ-025 good_count/err_count SHALL increment in the same cycle their pulse asserts; last_err updates only on pkt_bad.
REQ-026 byte_count SHALL add popcount(TSTRB) (0..32) per accepted beat, any state, in the following cycle.
REQ-027 Counters 32-bit, wrap 0xFFFFFFFF->0 silently.
REQ-028 rst_cntrs=1 SHALL zero all counters and last_err next cycle, overriding same-cycle increments; FSM unaffected.
REQ-029 TVALID without TREADY SHALL change no state; held beat re-evaluated when accepted.

Reset
REQ-030 S_AXI_ARESET=1: state=HDR, flag/code cleared, counters=0, last_err=0, pkt_good=pkt_bad=0, TREADY=0.
REQ-031 Reset mid-packet SHALL abandon it with no verdict; next accepted beat treated as header.

Verification
REQ-032 Two-beat packet with C_EXP_HDR/TUSER 0x04800040 then C_EXP_PAYLOAD,TLAST -> pkt_good one cycle, good_count=1, byte_count=64.
REQ-033 Single beat with TLAST=1 -> pkt_bad, err_count=1, last_err=1, byte_count=32.
REQ-034 Header bit 0 flipped, valid payload -> pkt_bad after beat 1, last_err=2; next good packet -> good_count=1.
REQ-035 Three-beat packet with valid beats 0/1 -> pkt_bad after beat 2, last_err=4, byte_count=96.
REQ-036 rx_pause toggled mid-packet with TVALID held -> beats counted once, pkt_good; rst_cntrs coincident with pkt_good -> all counters 0.
